// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - op codes, FSM states and op decode helpers for the divider
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_DIV  = 2'b00,
    DIV_DIVU = 2'b01,
    DIV_REM  = 2'b10,
    DIV_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    DIVS_IDLE = 3'd0,
    DIVS_PREP = 3'd1,
    DIVS_CALC = 3'd2,
    DIVS_FIX  = 3'd3,
    DIVS_DONE = 3'd4
  } div_state_e;

  // op[0]=0 selects the signed forms (DIV/REM), op[1]=1 selects the remainder.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_negate.sv
// rtl/div_negate.sv - conditional two's-complement negation
module div_negate #(
  parameter int N = 32
) (
  input  logic [N-1:0] in,
  input  logic         en,
  output logic [N-1:0] out
);

  assign out = en ? ((~in) + N'(1)) : in;

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle RV32M restoring divider (DIV/DIVU/REM/REMU)
module div_unit
  import div_unit_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = $clog2(N) + 1;

  div_state_e state, state_nxt;

  logic [N-1:0]  a_q, b_q, quo, rem, divisor, result_q;
  logic [1:0]    op_q;
  logic [CW-1:0] count;
  logic          q_neg, r_neg;

  logic [N-1:0]  a_mag, b_mag, quo_fix, rem_fix;
  logic          sgn, div_zero, overflow, special;
  logic [N:0]    rem_sh;
  logic [N+1:0]  trial;
  logic          trial_ok;
  logic          unused_trial_bit;

  assign sgn      = op_is_signed(op_q);
  assign div_zero = (b_q == '0);
  assign overflow = sgn && (a_q == {1'b1, {(N-1){1'b0}}}) && (b_q == '1);
  assign special  = div_zero | overflow;

  div_negate #(.N(N)) u_neg_a   (.in(a_q), .en(sgn & a_q[N-1]), .out(a_mag));
  div_negate #(.N(N)) u_neg_b   (.in(b_q), .en(sgn & b_q[N-1]), .out(b_mag));
  div_negate #(.N(N)) u_neg_quo (.in(quo), .en(q_neg),          .out(quo_fix));
  div_negate #(.N(N)) u_neg_rem (.in(rem), .en(r_neg),          .out(rem_fix));

  // One extra guard bit: an unsigned divisor near 2^N makes the shifted
  // partial remainder N+1 bits wide, so its sign needs bit N+1.
  assign rem_sh           = {rem, quo[N-1]};
  assign trial            = {1'b0, rem_sh} - {2'b00, divisor};
  assign trial_ok         = ~trial[N+1];
  assign unused_trial_bit = trial[N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DIVS_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIVS_IDLE: if (start) state_nxt = DIVS_PREP;
      DIVS_PREP: state_nxt = special ? DIVS_DONE : DIVS_CALC;
      DIVS_CALC: if (count == CW'(1)) state_nxt = DIVS_FIX;
      DIVS_FIX:  state_nxt = DIVS_DONE;
      DIVS_DONE: state_nxt = start ? DIVS_PREP : DIVS_IDLE;
      default:   state_nxt = DIVS_IDLE;
    endcase
    if (flush) state_nxt = DIVS_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      quo      <= '0;
      rem      <= '0;
      divisor  <= '0;
      count    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_q <= '0;
    end else if (!flush) begin
      case (state)
        DIVS_IDLE, DIVS_DONE: begin
          if (start) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
          end
        end
        DIVS_PREP: begin
          quo     <= a_mag;
          rem     <= '0;
          divisor <= b_mag;
          count   <= CW'(N);
          q_neg   <= sgn & (a_q[N-1] ^ b_q[N-1]);
          r_neg   <= sgn & a_q[N-1];
          if (div_zero)
            result_q <= op_is_rem(op_q) ? a_q : '1;
          else if (overflow)
            result_q <= (op_q == DIV_DIV) ? a_q : '0;
        end
        DIVS_CALC: begin
          quo   <= {quo[N-2:0], trial_ok};
          rem   <= trial_ok ? trial[N-1:0] : rem_sh[N-1:0];
          count <= count - CW'(1);
        end
        DIVS_FIX: begin
          result_q <= op_is_rem(op_q) ? rem_fix : quo_fix;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state == DIVS_PREP) || (state == DIVS_CALC) || (state == DIVS_FIX);
  assign done   = (state == DIVS_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit against an arithmetic reference
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  div_unit #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  logic [31:0] last_res = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx, sy;
    sx = x;
    sy = y;
    if (y == 32'h0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
      if (o[1]) return sx % sy;
      return sx / sy;
    end
    if (o[1]) return x % y;
    return x / y;
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (y == 32'h0) return 2;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
    return 35;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: result=%h at cycle %0d, no op outstanding", result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        tests++;
        if (result !== e.res) begin
          fails++;
          $display("FAIL result: got %h expected %h", result, e.res);
        end
        tests++;
        if (cyc != e.cyc) begin
          fails++;
          $display("FAIL latency: done at cycle %0d expected %0d", cyc, e.cyc);
        end
      end
    end
  end

  // Drives start for one edge; when push is set the reference result is queued.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.res = ref_div(o, x, y);
      e.cyc = cyc + ref_latency(o, x, y) - 1;
      sb.push_back(e);
      last_res = e.res;
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_prep: got %b expected 1", busy);
    end
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL done_timeout: no done within 60 cycles");
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    a     = 32'h0;
    b     = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",   {31'h0, busy}, 32'h0);
    check("reset_done",   {31'h0, done}, 32'h0);
    check("reset_result", result,        32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, each issued in the DONE cycle of the previous one.
    issue(2'b01, 32'd100,       32'd7,         1); wait_done();
    issue(2'b11, 32'd100,       32'd7,         1); wait_done();
    issue(2'b00, 32'hFFFF_FF9C, 32'd7,         1); wait_done();
    issue(2'b10, 32'hFFFF_FF9C, 32'd7,         1); wait_done();
    issue(2'b01, 32'd5,         32'd0,         1); wait_done();
    issue(2'b10, 32'd5,         32'd0,         1); wait_done();
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1); wait_done();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1); wait_done();
    issue(2'b01, 32'd9,         32'd3,         1); wait_done();
    issue(2'b11, 32'd9,         32'd4,         1); wait_done();
    check("directed_remu_9_4", result, 32'd1);

    // Flush in cycle 10 of a DIVU: no done, result holds.
    repeat (2) @(negedge clk);
    issue(2'b01, 32'd100, 32'd7, 0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'h0, busy}, 32'h0);
    repeat (40) @(negedge clk);
    check("flush_result_held", result, last_res);

    // Reset mid-CALC.
    issue(2'b00, 32'd12345, 32'd17, 0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_busy",   {31'h0, busy}, 32'h0);
    check("midreset_done",   {31'h0, done}, 32'h0);
    check("midreset_result", result,        32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized ops, mixing back-to-back and idle gaps.
    for (int n = 0; n < 200; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        4: rb = {1'b1, 31'($urandom)};
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(ro, ra, rb, 1);
      wait_done();
    end

    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d ops outstanding, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
